// File: rtl/depermutate_2.sv
// rtl/depermutate_2.sv - inverse coefficient depermutation with 2-entry elastic buffer
//
// Splits one natural-order row of DCT2 coefficients into the even/odd groups
// consumed by the inverse partial butterfly, buffers up to two mapped rows,
// and tags the last row of every transform block.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake (row from transpose memory)
//   N               size code 0..3 -> 4/8/16/32-point row
//   Y               packed row, coefficient k at Y[511-16k -: 16]
//   out_valid/ready downstream handshake (groups to inverse butterfly)
//   X2E, X2O        level-2 even/odd groups
//   X4O, X8O, X16O  odd groups of levels 4/8/16 (0 when unused at N)
//   N_out           size code travelling with the row
//   out_last        row is the final row of its block
module depermutate_2 (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          N,
  input  logic signed [511:0] Y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [15:0]  X2E  [0:1],
  output logic signed [15:0]  X2O  [0:1],
  output logic signed [15:0]  X4O  [0:3],
  output logic signed [15:0]  X8O  [0:7],
  output logic signed [15:0]  X16O [0:15],
  output logic [1:0]          N_out,
  output logic                out_last
);

  typedef struct packed {
    logic [1:0][15:0]  x2e;
    logic [1:0][15:0]  x2o;
    logic [3:0][15:0]  x4o;
    logic [7:0][15:0]  x8o;
    logic [15:0][15:0] x16o;
    logic [1:0]        n;
    logic              last;
  } entry_t;

  entry_t     mem [0:1];
  entry_t     mapped;
  entry_t     head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [4:0] row_idx;
  logic [1:0] prev_n;
  logic [4:0] eff_idx;
  logic [4:0] last_idx;
  logic       push_last;
  logic       push;
  logic       pop;

  function automatic logic [15:0] coef(input logic [511:0] y, input int k);
    return y[511-16*k -: 16];
  endfunction

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A change of transform size starts a new block, so the row is row 0.
  always_comb begin
    eff_idx = (N != prev_n) ? 5'd0 : row_idx;
    case (N)
      2'd0:    last_idx = 5'd3;
      2'd1:    last_idx = 5'd7;
      2'd2:    last_idx = 5'd15;
      default: last_idx = 5'd31;
    endcase
    push_last = (eff_idx == last_idx);
  end

  // Level-L odd group takes the odd multiples of S/(2L); X2E takes multiples
  // of S/2. Written out per size so each case is a fixed wiring pattern.
  always_comb begin
    mapped      = '0;
    mapped.n    = N;
    mapped.last = push_last;
    case (N)
      2'd0: begin
        for (int j = 0; j < 2; j++) begin
          mapped.x2e[j] = coef(Y, 2*j);
          mapped.x2o[j] = coef(Y, 2*j+1);
        end
      end
      2'd1: begin
        for (int j = 0; j < 4; j++) mapped.x4o[j] = coef(Y, 2*j+1);
        for (int j = 0; j < 2; j++) begin
          mapped.x2o[j] = coef(Y, 4*j+2);
          mapped.x2e[j] = coef(Y, 4*j);
        end
      end
      2'd2: begin
        for (int j = 0; j < 8; j++) mapped.x8o[j] = coef(Y, 2*j+1);
        for (int j = 0; j < 4; j++) mapped.x4o[j] = coef(Y, 4*j+2);
        for (int j = 0; j < 2; j++) begin
          mapped.x2o[j] = coef(Y, 8*j+4);
          mapped.x2e[j] = coef(Y, 8*j);
        end
      end
      default: begin
        for (int j = 0; j < 16; j++) mapped.x16o[j] = coef(Y, 2*j+1);
        for (int j = 0; j < 8; j++)  mapped.x8o[j]  = coef(Y, 4*j+2);
        for (int j = 0; j < 4; j++)  mapped.x4o[j]  = coef(Y, 8*j+4);
        for (int j = 0; j < 2; j++) begin
          mapped.x2o[j] = coef(Y, 16*j+8);
          mapped.x2e[j] = coef(Y, 16*j);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_idx <= 5'd0;
      prev_n  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        prev_n  <= N;
        row_idx <= push_last ? 5'd0 : eff_idx + 5'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are forced to zero whenever the buffer
  // is empty, and reset always empties it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mapped;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      X2E[j] = out_valid ? head.x2e[j] : 16'sd0;
      X2O[j] = out_valid ? head.x2o[j] : 16'sd0;
    end
    for (int j = 0; j < 4; j++)  X4O[j]  = out_valid ? head.x4o[j]  : 16'sd0;
    for (int j = 0; j < 8; j++)  X8O[j]  = out_valid ? head.x8o[j]  : 16'sd0;
    for (int j = 0; j < 16; j++) X16O[j] = out_valid ? head.x16o[j] : 16'sd0;
    N_out    = out_valid ? head.n    : 2'd0;
    out_last = out_valid ? head.last : 1'b0;
  end

endmodule

// File: tb/tb_depermutate_2.sv
// tb/tb_depermutate_2.sv - directed self-checking bench for depermutate_2
module tb_depermutate_2;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          n;
  logic signed [511:0] y;
  logic                out_valid;
  logic                out_ready;
  logic signed [15:0]  x2e  [0:1];
  logic signed [15:0]  x2o  [0:1];
  logic signed [15:0]  x4o  [0:3];
  logic signed [15:0]  x8o  [0:7];
  logic signed [15:0]  x16o [0:15];
  logic [1:0]          n_out;
  logic                out_last;

  int vectors;
  int miscompares;

  depermutate_2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .N        (n),
    .Y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .X2E      (x2e),
    .X2O      (x2o),
    .X4O      (x4o),
    .X8O      (x8o),
    .X16O     (x16o),
    .N_out    (n_out),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row with coefficient k = base + k for all 32 positions.
  function automatic logic [511:0] seq_row(input int base);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[511-16*k -: 16] = 16'(base + k);
    return r;
  endfunction

  task automatic chk_n3(input int r);
    int b;
    b = 32 * r;
    for (int j = 0; j < 16; j++) chk($sformatf("r%0d_x16o%0d", r, j), int'(x16o[j]), b + 2*j + 1);
    for (int j = 0; j < 8; j++)  chk($sformatf("r%0d_x8o%0d", r, j), int'(x8o[j]), b + 4*j + 2);
    for (int j = 0; j < 4; j++)  chk($sformatf("r%0d_x4o%0d", r, j), int'(x4o[j]), b + 8*j + 4);
    chk($sformatf("r%0d_x2o0", r), int'(x2o[0]), b + 8);
    chk($sformatf("r%0d_x2o1", r), int'(x2o[1]), b + 24);
    chk($sformatf("r%0d_x2e0", r), int'(x2e[0]), b);
    chk($sformatf("r%0d_x2e1", r), int'(x2e[1]), b + 16);
    chk($sformatf("r%0d_nout", r), int'(n_out), 3);
    chk($sformatf("r%0d_last", r), int'(out_last), (r == 31) ? 1 : 0);
    chk($sformatf("r%0d_ovalid", r), int'(out_valid), 1);
    chk($sformatf("r%0d_iready", r), int'(in_ready), 1);
  endtask

  // N=1 row seq_row(base): X4O[j]=base+2j+1, X2O[j]=base+4j+2, X2E[j]=base+4j.
  task automatic chk_n1(input string tag, input int base);
    chk({tag, "_x4o0"}, int'(x4o[0]), base + 1);
    chk({tag, "_x4o3"}, int'(x4o[3]), base + 7);
    chk({tag, "_x2o1"}, int'(x2o[1]), base + 6);
    chk({tag, "_x2e1"}, int'(x2e[1]), base + 4);
    chk({tag, "_x8o0"}, int'(x8o[0]), 0);
    chk({tag, "_nout"}, int'(n_out), 1);
    chk({tag, "_last"}, int'(out_last), 0);
  endtask

  initial begin
    logic [511:0] v;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    n           = 2'd0;
    y           = '0;

    // Reset state
    #3;
    chk("rst_ovalid", int'(out_valid), 0);
    chk("rst_iready", int'(in_ready), 1);
    chk("rst_nout", int'(n_out), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_x2e0", int'(x2e[0]), 0);
    chk("rst_x16o15", int'(x16o[15]), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single N=0 row: {10,-3,7,1}
    v = '0;
    v[511 -: 16] = 16'd10;
    v[495 -: 16] = 16'hFFFD;
    v[479 -: 16] = 16'd7;
    v[463 -: 16] = 16'd1;
    y = v; n = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("n0_ovalid", int'(out_valid), 1);
    chk("n0_x2e0", int'(x2e[0]), 10);
    chk("n0_x2e1", int'(x2e[1]), 7);
    chk("n0_x2o0", int'(x2o[0]), -3);
    chk("n0_x2o1", int'(x2o[1]), 1);
    chk("n0_x4o0", int'(x4o[0]), 0);
    chk("n0_x8o7", int'(x8o[7]), 0);
    chk("n0_x16o0", int'(x16o[0]), 0);
    chk("n0_nout", int'(n_out), 0);
    chk("n0_last", int'(out_last), 0);
    tick();
    chk("n0_drain", int'(out_valid), 0);

    // 32 back-to-back N=3 rows, c_k = 32r+k
    n = 2'd3;
    for (int r = 0; r < 32; r++) begin
      y = seq_row(32 * r); in_valid = 1'b1;
      tick();
      chk_n3(r);
    end
    in_valid = 1'b0;
    tick();
    chk("n3_drain", int'(out_valid), 0);

    // Backpressure with three N=1 rows
    out_ready = 1'b0; n = 2'd1;
    y = seq_row(100); in_valid = 1'b1;
    tick();
    chk("bp_ir1", int'(in_ready), 1);
    chk_n1("bp_a1", 100);
    y = seq_row(200);
    tick();
    chk("bp_ir2", int'(in_ready), 0);
    chk_n1("bp_a2", 100);
    y = seq_row(300);
    tick();
    chk("bp_ir3", int'(in_ready), 0);
    chk("bp_ov3", int'(out_valid), 1);
    chk_n1("bp_a3", 100);
    out_ready = 1'b1;
    tick();
    chk_n1("bp_b", 200);
    tick();
    in_valid = 1'b0;
    chk_n1("bp_c", 300);
    tick();
    chk("bp_drain", int'(out_valid), 0);

    // N change restarts the block count: last on 16th N=2 row
    n = 2'd2;
    for (int i = 0; i < 16; i++) begin
      y = seq_row(1000 + 40 * i); in_valid = 1'b1;
      tick();
      chk($sformatf("n2_%0d_x8o7", i), int'(x8o[7]), 1000 + 40 * i + 15);
      chk($sformatf("n2_%0d_x4o3", i), int'(x4o[3]), 1000 + 40 * i + 14);
      chk($sformatf("n2_%0d_x2o1", i), int'(x2o[1]), 1000 + 40 * i + 12);
      chk($sformatf("n2_%0d_x2e1", i), int'(x2e[1]), 1000 + 40 * i + 8);
      chk($sformatf("n2_%0d_x16o0", i), int'(x16o[0]), 0);
      chk($sformatf("n2_%0d_last", i), int'(out_last), (i == 15) ? 1 : 0);
    end
    in_valid = 1'b0;
    tick();

    // Steady state at count 1 with simultaneous push/pop
    n = 2'd0;
    for (int i = 0; i < 11; i++) begin
      y = seq_row(2000 + 8 * i); in_valid = 1'b1;
      tick();
      chk($sformatf("c1_%0d_iready", i), int'(in_ready), 1);
      chk($sformatf("c1_%0d_ovalid", i), int'(out_valid), 1);
      chk($sformatf("c1_%0d_x2e0", i), int'(x2e[0]), 2000 + 8 * i);
      chk($sformatf("c1_%0d_x2o1", i), int'(x2o[1]), 2000 + 8 * i + 3);
    end
    in_valid = 1'b0;
    tick();

    // Reset with two rows buffered
    out_ready = 1'b0;
    y = seq_row(3000); in_valid = 1'b1;
    tick();
    y = seq_row(3010);
    tick();
    in_valid = 1'b0;
    chk("rb_iready", int'(in_ready), 0);
    chk("rb_ovalid", int'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ra_ovalid", int'(out_valid), 0);
    chk("ra_x2e0", int'(x2e[0]), 0);
    chk("ra_x2o1", int'(x2o[1]), 0);
    chk("ra_nout", int'(n_out), 0);
    tick();
    rst_n = 1'b1;
    chk("ra_iready", int'(in_ready), 1);
    chk("ra_ovalid2", int'(out_valid), 0);

    // First row after reset is row 0: last on 4th N=0 row
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y = seq_row(4000 + 4 * i); in_valid = 1'b1;
      tick();
      chk($sformatf("pr_%0d_x2e0", i), int'(x2e[0]), 4000 + 4 * i);
      chk($sformatf("pr_%0d_last", i), int'(out_last), (i == 3) ? 1 : 0);
    end
    in_valid = 1'b0;
    tick();
    chk("pr_drain", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/depermutate_2.md
# depermutate_2

Inverse-direction companion to the forward coefficient permutation stage of the DCT2 datapath. It accepts one row of transform coefficients in natural frequency order, packed as a 512-bit word. It splits the row into the even/odd groups that the inverse partial butterfly consumes: X2E, X2O, X4O, X8O and X16O. It sits between the transpose memory and the inverse butterfly. A 2-entry elastic buffer with valid/ready handshakes on both sides decouples the two, and a per-block row counter flags the last row of each transform block.

## Interface
- No parameters. Coefficient width is fixed at 16 bits signed; maximum row length is 32.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input row valid.
- in_ready  output  1  buffer can accept a row.
- N  input  2  transform size code: 0→4-point, 1→8, 2→16, 3→32.
- Y  input  512, signed  packed row; coefficient k is Y[511-16k -: 16]; bits beyond 16·S are ignored.
- out_valid  output  1  output groups valid.
- out_ready  input  1  downstream accepts the groups.
- X2E[0:1], X2O[0:1]  output  2×16 each, signed  even/odd groups, level 2.
- X4O[0:3]  output  4×16, signed  odd group, level 4.
- X8O[0:7]  output  8×16, signed  odd group, level 8.
- X16O[0:15]  output  16×16, signed  odd group, level 16.
- N_out  output  2  size code travelling with the row.
- out_last  output  1  row is the last row (row S-1) of its block.

## Operation
- Row length S = 4<<N.
- Coefficient mapping for coefficient k, 0≤k<S, with S = 2^m:
  - k odd → group of size S/2 (X(S/2)O), index (k-1)/2.
  - k ≡ 2 mod 4 → X(S/4)O, index (k-2)/4; continue the same pattern down to level 2.
  - k ≡ S/4 mod S/2 → X2O[(k-S/4)/(S/2)].
  - k ≡ 0 mod S/2 → X2E[k/(S/2)].
  - S=4 example: c0→X2E[0], c1→X2O[0], c2→X2E[1], c3→X2O[1].
  - S=32 example: c1→X16O[0], c2→X8O[0], c4→X4O[0], c8→X2O[0], c16→X2E[1], c31→X16O[15].
- Groups not used at the current N, for example X16O when N<3, are driven to 0.
- Mapping is applied at push time. Each buffer entry stores the mapped groups, N, and the last flag.
- Buffer: 2-entry FIFO with occupancy count 0..2.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2). It has no combinational dependence on out_ready.
  - out_valid = (count != 0). Outputs always present the head entry.
  - Simultaneous push and pop at count 1 leaves count at 1; order is preserved.
- Row counter row_idx (5 bits) is evaluated at push:
  - If the pushed N differs from the N of the previous push, the row is treated as row 0.
  - last flag = (row_idx == S-1).
  - On push, row_idx becomes 0 if last, otherwise row_idx+1.
- While out_valid && !out_ready, all outputs are held stable.

## Timing
- Reset (async assert, synchronous-release tolerant): count=0, row_idx=0, previous-N register=0.
- Reset values of outputs: out_valid=0, in_ready=1, every group output 0, N_out=0, out_last=0.
- Latency: a row pushed at edge t into an empty buffer is visible with out_valid=1 after edge t.
- Throughput: 1 row/cycle while out_ready stays high.
- Backpressure: the buffer absorbs 2 rows. in_ready drops in the cycle after the second push if no pop occurs.
- Reset mid-operation: buffered rows and the row count are discarded; the first row after reset is row 0.

## Test plan
- Reset, then push N=0 with Y={16'sd10,16'sd-3,16'sd7,16'sd1,448'd0} and out_ready=1 → next cycle: X2E={10,7}, X2O={-3,1}, all other groups 0, N_out=0, out_last=0.
- Push 32 rows with N=3 back-to-back, row r using coefficients c_k=32r+k → each output has X16O[j]=32r+2j+1, X8O[j]=32r+4j+2, X4O[j]=32r+8j+4, X2O={32r+8,32r+24}, X2E={32r,32r+16}; out_last=1 only on row 31; no bubbles.
- Hold out_ready=0 and push 3 rows → in_ready=0 after 2 pushes; third row stalls. Raise out_ready → rows emerge in order with outputs stable while stalled.
- Push 3 N=1 rows, then an N=2 row → the N=2 row restarts the count; its out_last=1 occurs on the 16th consecutive N=2 row.
- Assert rst_n=0 with 2 rows buffered → out_valid=0 and all group outputs 0 immediately; in_ready=1 after release.
- Push with count=1 and out_ready=1 for 10 cycles → count stays 1, in_ready stays 1, data stays in order.
